// File: rtl/pwm_switch_array.sv
// CH-channel set/clear PWM with shared tick prescaler and shadow config that commits at each wrap.
// Latency: pwm/wrap/cnt register on the ticking edge; no backpressure, writes always accepted.
module pwm_switch_array #(
  parameter int CH = 4,
  parameter int CW = 7,
  parameter int PW = 8,
  localparam int AW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [PW-1:0]    prescale_i,
  input  logic [CH-1:0]    ch_en_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_ch_i,
  input  logic [CW-1:0]    wr_period_i,
  input  logic [CW-1:0]    wr_set_i,
  input  logic [CW-1:0]    wr_clr_i,
  output logic             tick_o,
  output logic [CH-1:0]    pwm_o,
  output logic [CH-1:0]    wrap_o,
  output logic [CH*CW-1:0] cnt_o
);

  typedef struct packed {
    logic [CW-1:0] per;
    logic [CW-1:0] set;
    logic [CW-1:0] clr;
  } cfg_t;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];
  cfg_t          sh_q  [CH];
  cfg_t          sh_d  [CH];
  cfg_t          ac_q  [CH];
  cfg_t          ac_d  [CH];
  logic [CH-1:0] pwm_q, pwm_d;
  logic [CH-1:0] wrap_q, wrap_d;
  logic [CW-1:0] nxt;
  cfg_t          eff;

  always_comb begin
    tick_o = en_i && (pcnt_q == prescale_i);
    pcnt_d = pcnt_q;
    if (en_i) begin
      // A prescale lowered below pcnt lets pcnt run on to its natural rollover.
      pcnt_d = tick_o ? '0 : pcnt_q + 1'b1;
    end
    pwm_d  = pwm_q;
    wrap_d = '0;
    nxt    = '0;
    eff    = '0;
    for (int i = 0; i < CH; i++) begin
      sh_d[i]  = sh_q[i];
      ac_d[i]  = ac_q[i];
      cnt_d[i] = cnt_q[i];
      if (wr_en_i && (int'(wr_ch_i) == i)) begin
        sh_d[i] = {wr_period_i, wr_set_i, wr_clr_i};
      end
      if (!ch_en_i[i]) begin
        ac_d[i]  = sh_q[i];
        cnt_d[i] = '0;
        pwm_d[i] = 1'b0;
      end else if (tick_o) begin
        eff = ac_q[i];
        if (cnt_q[i] == ac_q[i].per) begin
          nxt       = '0;
          wrap_d[i] = 1'b1;
          eff       = sh_q[i];
          ac_d[i]   = sh_q[i];
        end else begin
          nxt = cnt_q[i] + 1'b1;
        end
        cnt_d[i] = nxt;
        // Clear has priority so set==clr keeps the line low.
        if ((nxt == eff.clr) && (eff.clr <= eff.per)) begin
          pwm_d[i] = 1'b0;
        end else if ((nxt == eff.set) && (eff.set <= eff.per)) begin
          pwm_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= '0;
      pwm_q  <= '0;
      wrap_q <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
        sh_q[i]  <= '0;
        ac_q[i]  <= '0;
      end
    end else begin
      pcnt_q <= pcnt_d;
      pwm_q  <= pwm_d;
      wrap_q <= wrap_d;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        sh_q[i]  <= sh_d[i];
        ac_q[i]  <= ac_d[i];
      end
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_o[i*CW +: CW] = cnt_q[i];
    end
  end

  assign pwm_o  = pwm_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_pwm_switch_array.sv
// Scoreboard bench for pwm_switch_array; CH=5 leaves index codes 5..7 free for out-of-range writes.
`timescale 1ns/1ps
module tb_pwm_switch_array;
  localparam int CH = 5;
  localparam int CW = 7;
  localparam int PW = 8;
  localparam int AW = 3;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             en_i, wr_en_i, tick_o;
  logic [PW-1:0]    prescale_i;
  logic [CH-1:0]    ch_en_i, pwm_o, wrap_o;
  logic [AW-1:0]    wr_ch_i;
  logic [CW-1:0]    wr_period_i, wr_set_i, wr_clr_i;
  logic [CH*CW-1:0] cnt_o;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [CW-1:0] c; logic p; logic w; } ch_t;
  typedef struct packed { ch_t a; ch_t b; logic t; } exp_t;
  exp_t q[$];

  always #5 clk_i = ~clk_i;

  pwm_switch_array #(.CH(CH), .CW(CW), .PW(PW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .prescale_i(prescale_i),
    .ch_en_i(ch_en_i), .wr_en_i(wr_en_i), .wr_ch_i(wr_ch_i),
    .wr_period_i(wr_period_i), .wr_set_i(wr_set_i), .wr_clr_i(wr_clr_i),
    .tick_o(tick_o), .pwm_o(pwm_o), .wrap_o(wrap_o), .cnt_o(cnt_o)
  );

  function automatic ch_t obs(input int c);
    ch_t r;
    r.c = cnt_o[c*CW +: CW];
    r.p = pwm_o[c];
    r.w = wrap_o[c];
    return r;
  endfunction

  // Closed form for ch0 with period 9, set 2, clr 7, tick every p+1 clocks from j=0.
  function automatic exp_t ref_run(input int j, input int p);
    exp_t e;
    int   c;
    c     = (j / (p + 1)) % 10;
    e     = '0;
    e.a.c = CW'(c);
    e.a.p = (c >= 2 && c <= 6);
    e.a.w = (j > 0 && (j % (p + 1)) == 0 && c == 0);
    e.t   = ((j % (p + 1)) == p);
    return e;
  endfunction

  function automatic ch_t mk(input int c, input bit p, input bit w);
    ch_t r;
    r.c = CW'(c);
    r.p = p;
    r.w = w;
    return r;
  endfunction

  task automatic do_reset();
    en_i = 1'b0; ch_en_i = '0; wr_en_i = 1'b0; prescale_i = '0;
    wr_ch_i = '0; wr_period_i = '0; wr_set_i = '0; wr_clr_i = '0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Disables all channels, writes one shadow, and leaves one extra edge for the active copy.
  task automatic load(input int c, input int per, input int st, input int cl);
    en_i = 1'b1; prescale_i = '0; ch_en_i = '0;
    wr_en_i = 1'b1; wr_ch_i = AW'(c);
    wr_period_i = CW'(per); wr_set_i = CW'(st); wr_clr_i = CW'(cl);
    @(negedge clk_i);
    wr_en_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    en_i = 1'b0; ch_en_i = '0; wr_en_i = 1'b0; prescale_i = '0;
    wr_ch_i = '0; wr_period_i = '0; wr_set_i = '0; wr_clr_i = '0;
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (cnt_o !== '0 || pwm_o !== '0 || wrap_o !== '0) begin
      failures++;
      $display("FAIL reset_state cnt=%h pwm=%b wrap=%b exp all zero", cnt_o, pwm_o, wrap_o);
    end
    checks++;
    if (tick_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_tick got=%b exp=0", tick_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    exp_t e; ch_t o; int j;
    do_reset();
    load(0, 9, 2, 7);
    ch_en_i = CH'(1);
    for (int k = 1; k <= 30; k++) q.push_back(ref_run(k, 0));
    j = 0;
    while (q.size() > 0) begin
      @(negedge clk_i);
      j++; e = q.pop_front(); o = obs(0);
      checks++;
      if (o !== e.a) begin failures++; $display("FAIL basic j=%0d {cnt,pwm,wrap} got=%h exp=%h", j, o, e.a); end
      checks++;
      if (tick_o !== e.t) begin failures++; $display("FAIL basic_tick j=%0d got=%b exp=%b", j, tick_o, e.t); end
    end
  endtask

  task automatic test_prescaler();
    exp_t e; ch_t o; int j;
    do_reset();
    load(0, 9, 2, 7);
    prescale_i = 8'd3; ch_en_i = CH'(1);
    for (int k = 1; k <= 80; k++) q.push_back(ref_run(k, 3));
    j = 0;
    while (q.size() > 0) begin
      @(negedge clk_i);
      j++; e = q.pop_front(); o = obs(0);
      checks++;
      if (o !== e.a) begin failures++; $display("FAIL prescale j=%0d {cnt,pwm,wrap} got=%h exp=%h", j, o, e.a); end
      checks++;
      if (tick_o !== e.t) begin failures++; $display("FAIL prescale_tick j=%0d got=%b exp=%b", j, tick_o, e.t); end
    end
  endtask

  task automatic test_freeze();
    exp_t e; ch_t o; int s;
    do_reset();
    load(0, 9, 2, 7);
    prescale_i = 8'd2; ch_en_i = CH'(1);
    for (int k = 1; k <= 13; k++) q.push_back(ref_run(k, 2));
    for (int k = 0; k < 15; k++) begin
      e = ref_run(13, 2); e.t = 1'b0; e.a.w = 1'b0;
      q.push_back(e);
    end
    for (int k = 14; k <= 35; k++) q.push_back(ref_run(k, 2));
    s = 0;
    while (q.size() > 0) begin
      @(negedge clk_i);
      s++; e = q.pop_front(); o = obs(0);
      checks++;
      if (o !== e.a) begin failures++; $display("FAIL freeze s=%0d {cnt,pwm,wrap} got=%h exp=%h", s, o, e.a); end
      checks++;
      if (tick_o !== e.t) begin failures++; $display("FAIL freeze_tick s=%0d got=%b exp=%b", s, tick_o, e.t); end
      if (s == 13) en_i = 1'b0;
      else if (s == 28) en_i = 1'b1;
    end
  endtask

  task automatic test_shadow();
    exp_t e; ch_t o; int j;
    int segs[5] = '{4, 4, 4, 6, 6};
    do_reset();
    load(0, 9, 2, 7);
    ch_en_i = CH'(1);
    for (int k = 1; k <= 9; k++) begin
      e = '0; e.t = 1'b1; e.a = mk(k, (k >= 2 && k <= 6), 1'b0); q.push_back(e);
    end
    foreach (segs[s]) begin
      e = '0; e.t = 1'b1; e.a = mk(0, 1'b0, 1'b1); q.push_back(e);
      for (int c = 1; c <= segs[s]; c++) begin
        e = '0; e.t = 1'b1; e.a = mk(c, (c >= 1 && c <= 2), 1'b0); q.push_back(e);
      end
    end
    j = 0;
    while (q.size() > 0) begin
      @(negedge clk_i);
      j++; e = q.pop_front(); o = obs(0);
      checks++;
      if (o !== e.a) begin failures++; $display("FAIL shadow j=%0d {cnt,pwm,wrap} got=%h exp=%h", j, o, e.a); end
      wr_en_i = 1'b0;
      if (j == 5 || j == 19) begin
        wr_en_i = 1'b1; wr_ch_i = '0;
        wr_period_i = (j == 5) ? 7'd4 : 7'd6; wr_set_i = 7'd1; wr_clr_i = 7'd3;
      end
    end
  endtask

  task automatic test_degenerate();
    exp_t e; ch_t o; int per, st, cl;
    for (int cs = 0; cs < 3; cs++) begin
      per = (cs == 2) ? 0 : 9;
      st  = (cs == 0) ? 3 : (cs == 1) ? 12 : 0;
      cl  = (cs == 0) ? 3 : (cs == 1) ? 5 : 1;
      do_reset();
      load(0, per, st, cl);
      ch_en_i = CH'(1);
      for (int k = 1; k <= 12; k++) begin
        e = '0; e.t = 1'b1;
        e.a = (cs == 2) ? mk(0, 1'b1, 1'b1) : mk(k % 10, 1'b0, (k % 10) == 0);
        q.push_back(e);
      end
      for (int k = 1; q.size() > 0; k++) begin
        @(negedge clk_i);
        e = q.pop_front(); o = obs(0);
        checks++;
        if (o !== e.a) begin failures++; $display("FAIL degenerate case=%0d k=%0d {cnt,pwm,wrap} got=%h exp=%h", cs, k, o, e.a); end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e; ch_t o;
    do_reset();
    load(0, 9, 2, 7);
    ch_en_i = CH'(1);
    for (int k = 1; k <= 4; k++) q.push_back(ref_run(k, 0));
    for (int k = 1; q.size() > 0; k++) begin
      @(negedge clk_i);
      e = q.pop_front(); o = obs(0);
      checks++;
      if (o !== e.a) begin failures++; $display("FAIL async_pre k=%0d {cnt,pwm,wrap} got=%h exp=%h", k, o, e.a); end
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (pwm_o !== '0 || cnt_o !== '0 || wrap_o !== '0) begin
      failures++;
      $display("FAIL async_reset pwm=%b cnt=%h wrap=%b exp all zero", pwm_o, cnt_o, wrap_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    // Config registers are cleared too, so ch0 now runs period 0 with set==clr==0.
    for (int k = 1; k <= 3; k++) begin
      e = '0; e.t = 1'b1; e.a = mk(0, 1'b0, 1'b1); q.push_back(e);
    end
    for (int k = 1; q.size() > 0; k++) begin
      @(negedge clk_i);
      e = q.pop_front(); o = obs(0);
      checks++;
      if (o !== e.a) begin failures++; $display("FAIL async_post k=%0d {cnt,pwm,wrap} got=%h exp=%h", k, o, e.a); end
    end
  endtask

  task automatic test_multichannel();
    exp_t e; ch_t o0, o1; int j, m;
    do_reset();
    load(0, 78, 0, 40);
    load(1, 79, 0, 40);
    ch_en_i = CH'(3);
    for (int k = 1; k <= 245; k++) begin
      e = '0; e.t = 1'b1;
      e.a = mk(k % 79, (k >= 79 && (k % 79) < 40), (k % 79) == 0);
      if (k <= 170) begin
        e.b = mk(k % 80, (k >= 80 && (k % 80) < 40), (k % 80) == 0);
      end else if (k <= 172) begin
        e.b = mk(0, 1'b0, 1'b0);
      end else begin
        m = k - 172;
        e.b = mk(m % 6, ((m % 6) >= 1 && (m % 6) <= 2), (m % 6) == 0);
      end
      q.push_back(e);
    end
    j = 0;
    while (q.size() > 0) begin
      @(negedge clk_i);
      j++; e = q.pop_front(); o0 = obs(0); o1 = obs(1);
      checks++;
      if (o0 !== e.a) begin failures++; $display("FAIL multi_ch0 j=%0d {cnt,pwm,wrap} got=%h exp=%h", j, o0, e.a); end
      checks++;
      if (o1 !== e.b) begin failures++; $display("FAIL multi_ch1 j=%0d {cnt,pwm,wrap} got=%h exp=%h", j, o1, e.b); end
      wr_en_i = 1'b0;
      if (j == 170) begin
        ch_en_i = CH'(1);
        wr_en_i = 1'b1; wr_ch_i = 3'd1; wr_period_i = 7'd5; wr_set_i = 7'd1; wr_clr_i = 7'd3;
      end else if (j == 171) begin
        wr_en_i = 1'b1; wr_ch_i = 3'd5; wr_period_i = 7'd3; wr_set_i = 7'd0; wr_clr_i = 7'd1;
      end else if (j == 172) begin
        ch_en_i = CH'(3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescaler();
    test_freeze();
    test_shadow();
    test_degenerate();
    test_async_reset();
    test_multichannel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
